lif_array_scheduler: RTL

- Time-multiplexes one leaky-integrate-fire update datapath across NUM_NEURONS neurons, each with an 8-bit membrane state held in a register file.
- A tick pulse starts one sweep, which updates every neuron in index order, one neuron per cycle.
- Spikes become neuron-ID events in a small FIFO with a valid/ready output handshake.
- Sits between the stimulus/config front end and the downstream spike consumer.

---
 rtl/lif_array_scheduler_if.sv | 21 ++
 rtl/lif_array_scheduler.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/lif_array_scheduler_if.sv
// Spike-event stream between the LIF scheduler and the downstream consumer.
// The master side owns the event FIFO head; the slave side returns ready.
interface lif_array_scheduler_if #(
    parameter int ID_W = 2
);
    logic            ev_valid;
    logic            ev_ready;
    logic [ID_W-1:0] ev_id;

    modport master (
        output ev_valid,
        output ev_id,
        input  ev_ready
    );

    modport slave (
        input  ev_valid,
        input  ev_id,
        output ev_ready
    );
endinterface

// File: rtl/lif_array_scheduler.sv
// Time-multiplexed leaky-integrate-fire array. One shared update datapath walks
// the neurons in index order on every tick. Spikes become neuron-ID events in a
// first-word-fall-through FIFO. A full FIFO stalls the sweep, so no event is lost.
module lif_array_scheduler #(
    parameter int         NUM_NEURONS = 4,
    parameter int         ID_W        = 2,
    parameter int         FIFO_DEPTH  = 4,
    parameter logic [7:0] THRESH_RST  = 8'd230
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cur_we,
    input  logic [ID_W-1:0]       cur_addr,
    input  logic [7:0]            cur_data,
    input  logic                  thr_we,
    input  logic [7:0]            thr_data,
    input  logic                  tick,
    output logic                  busy,
    output logic                  sweep_done,
    output logic                  overrun,
    lif_array_scheduler_if.master ev,
    input  logic [ID_W-1:0]       rd_addr,
    output logic [7:0]            rd_state
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fsm_t;

    fsm_t            state_q, state_d;
    logic [ID_W-1:0] idx_q;
    logic [7:0]      thr_q;
    logic            overrun_q;
    logic            in_run;

    logic [7:0] state_mem [NUM_NEURONS];
    logic [7:0] cur_mem   [NUM_NEURONS];

    logic [ID_W-1:0]  fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic             fifo_full, fifo_empty;

    logic [7:0] s_cur, c_cur, next_val;
    logic [9:0] sum;
    logic       spike, last, pop, stall, advance, push;

    // Datapath operands for the neuron under the pointer.
    assign s_cur = state_mem[idx_q];
    assign c_cur = cur_mem[idx_q];
    assign spike = (s_cur >= thr_q);
    assign last  = (idx_q == ID_W'(NUM_NEURONS - 1));

    // Leak is s*(7/8) built from shifts. The sum fits in 10 bits, so it saturates instead of wrapping.
    assign sum      = {2'b00, c_cur} + {3'b000, s_cur[7:1]} + {4'b0000, s_cur[7:2]} + {5'b00000, s_cur[7:3]};
    assign next_val = (sum > 10'd255) ? 8'hFF : sum[7:0];

    // FIFO status and handshake.
    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));
    assign pop        = !fifo_empty && ev.ev_ready;

    // A spike that cannot be queued holds the sweep. A same-cycle pop frees a slot.
    assign stall   = in_run && spike && fifo_full && !pop;
    assign advance = in_run && !stall;
    assign push    = advance && spike;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // FSM next-state logic.
    always_comb begin
        // NOTE: default first, so no path leaves state_d unassigned and no latch is inferred.
        state_d = state_q;
        case (state_q)
            IDLE:    if (tick) state_d = RUN;
            RUN:     if (advance && last) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs.
    always_comb begin
        busy       = 1'b0;
        sweep_done = 1'b0;
        in_run     = 1'b0;
        case (state_q)
            RUN: begin
                busy   = 1'b1;
                in_run = 1'b1;
            end
            DONE: begin
                busy       = 1'b1;
                sweep_done = 1'b1;
            end
            default: ;
        endcase
    end

    // Neuron pointer: parked at 0 while idle, advances only on unstalled RUN cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)               idx_q <= '0;
        else if (state_q == IDLE) idx_q <= '0;
        else if (advance)         idx_q <= idx_q + 1'b1;
    end

    // Threshold register and the sticky overrun flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            thr_q     <= THRESH_RST;
            overrun_q <= 1'b0;
        end else begin
            if (thr_we)        thr_q     <= thr_data;
            if (tick && busy)  overrun_q <= 1'b1;
        end
    end

    // Membrane and current register files. The update reads the pre-edge current,
    // so a same-cycle write to the active neuron lands for the next sweep.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: these register files are software-visible and must read 0 after reset, so they
        // are reset. The FIFO storage below is not, because its empty state hides stale entries.
        if (!rst_n) begin
            for (int i = 0; i < NUM_NEURONS; i++) begin
                state_mem[i] <= 8'd0;
                cur_mem[i]   <= 8'd0;
            end
        end else begin
            if (cur_we)  cur_mem[cur_addr] <= cur_data;
            if (advance) state_mem[idx_q]  <= spike ? 8'd0 : next_val;
        end
    end

    // FIFO storage, written at the tail.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= idx_q;
    end

    // FIFO pointers and occupancy. A push and a pop in one cycle leave the count unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    assign overrun     = overrun_q;
    assign ev.ev_valid = !fifo_empty;
    assign ev.ev_id    = fifo_mem[rd_ptr];
    assign rd_state    = state_mem[rd_addr];

endmodule
